sh_hf_adaptor_fifo: RTL and testbench

SH_HF_ADAPTOR_FIFO -- requirements
Module: sh_hf_adaptor_fifo

---
 rtl/sh_hf_adaptor_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_sh_hf_adaptor_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_hf_adaptor_fifo.sv
// sh_hf_adaptor_fifo: Steelhorse-to-LSAB adaptor. Incoming words pass through
// a holdback stage (two stages when the trailing CRC word is stripped) before
// entering a small FIFO that is drained one entry per owned LSAB turn. Each
// frame end pushes a tagged entry that surfaces as IRQ alongside its last word.
module sh_hf_adaptor_fifo #(
    parameter int         DW         = 32,
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [1:0] MY_SLOT    = 2'h0,
    parameter int         STRIP_CRC  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            LSAB_TURN,
    input  logic [DW-1:0]         DATA_FROM_ETH,
    input  logic                  WRITE_IN,
    input  logic                  NEW_PCKT,
    input  logic                  NEW_PCKT_VALID,
    output logic [DW-1:0]         DATA_OUT,
    output logic                  WRITE,
    output logic                  IRQ,
    output logic                  IRQ_VLD,
    output logic                  OVERFLOW,
    output logic [DEPTH_LOG2:0]   LEVEL
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam int                  EW       = DW + 3;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // FIFO storage: entry = {tag, vld, nodata, data}
    logic [EW-1:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     level;

    // Holdback stages: p0 newest, p1 older
    logic [DW-1:0]           data_p0;
    logic [DW-1:0]           data_p1;
    logic                    vld_p0;
    logic                    vld_p1;
    logic [DW-1:0]           data_p0_n;
    logic [DW-1:0]           data_p1_n;
    logic                    vld_p0_n;
    logic                    vld_p1_n;

    logic                    new_pckt_prev;
    logic                    frame_drop;
    logic                    frame_drop_n;
    logic                    pend_tag;
    logic                    pend_tag_n;

    logic                    my_turn;
    logic                    fe;
    logic                    full;
    logic                    empty;
    logic                    pop;

    // Push request coming from the frame path, before arbitration with a pending tag
    logic                    frame_req;
    logic                    frame_tag;
    logic                    frame_nodata;
    logic [DW-1:0]           frame_data;
    logic                    frame_acc;
    logic                    pend_go;
    logic                    push_ok;
    logic                    push_lost;
    logic [EW-1:0]           push_entry;

    logic [EW-1:0]           rd_entry;

    assign my_turn  = (LSAB_TURN == MY_SLOT);
    assign fe       = NEW_PCKT && !new_pckt_prev;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign pop      = my_turn && !empty;
    assign rd_entry = mem[rd_ptr];
    assign LEVEL    = level;

    // Stage shifting, frame-end tagging and push arbitration
    always_comb begin
        data_p0_n    = data_p0;
        data_p1_n    = data_p1;
        vld_p0_n     = vld_p0;
        vld_p1_n     = vld_p1;
        frame_req    = 1'b0;
        frame_tag    = 1'b0;
        frame_nodata = 1'b0;
        frame_data   = data_p0;

        // A new word shifts in; the oldest stage leaves only when every stage is full
        if (WRITE_IN) begin
            if (STRIP_CRC != 0) begin
                if (vld_p1 && vld_p0) begin
                    frame_req  = 1'b1;
                    frame_data = data_p1;
                end
                data_p1_n = data_p0;
                vld_p1_n  = vld_p0;
            end else if (vld_p0) begin
                frame_req  = 1'b1;
                frame_data = data_p0;
            end
            data_p0_n = DATA_FROM_ETH;
            vld_p0_n  = 1'b1;
        end

        // Frame end acts on the already-shifted stages and replaces any plain push
        if (fe) begin
            frame_req = 1'b1;
            frame_tag = 1'b1;
            if (STRIP_CRC != 0) begin
                frame_data   = data_p1_n;
                frame_nodata = !vld_p1_n;
            end else begin
                frame_data   = data_p0_n;
                frame_nodata = !vld_p0_n;
            end
            vld_p0_n = 1'b0;
            vld_p1_n = 1'b0;
        end

        // A tag that was lost to a full FIFO takes the first slot that frees up
        pend_go   = pend_tag && (!full || pop);
        frame_acc = frame_req && !pend_go && (!full || pop);
        push_ok   = pend_go || frame_acc;
        push_lost = frame_req && !frame_acc;

        if (pend_go) begin
            push_entry = {1'b1, 1'b0, 1'b1, {DW{1'b0}}};
        end else begin
            push_entry = {frame_tag, NEW_PCKT_VALID && !frame_drop, frame_nodata, frame_data};
        end

        pend_tag_n = (pend_tag && !pend_go) || (push_lost && frame_tag);

        frame_drop_n = frame_drop;
        if (pend_go || (frame_acc && frame_tag)) begin
            frame_drop_n = 1'b0;
        end
        if (push_lost) begin
            frame_drop_n = 1'b1;
        end
    end

    // FIFO storage write; contents need no reset since level gates every read
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Control state: stages, pointers, occupancy and frame bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_p0       <= '0;
            data_p1       <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            new_pckt_prev <= 1'b0;
            frame_drop    <= 1'b0;
            pend_tag      <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            data_p0       <= data_p0_n;
            data_p1       <= data_p1_n;
            vld_p0        <= vld_p0_n;
            vld_p1        <= vld_p1_n;
            new_pckt_prev <= NEW_PCKT;
            frame_drop    <= frame_drop_n;
            pend_tag      <= pend_tag_n;
            if (push_lost) begin
                OVERFLOW <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // LSAB side: one entry per owned turn; outputs hold outside our turn
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATA_OUT <= '0;
            WRITE    <= 1'b0;
            IRQ      <= 1'b0;
            IRQ_VLD  <= 1'b0;
        end else if (my_turn) begin
            if (!empty) begin
                DATA_OUT <= rd_entry[DW-1:0];
                WRITE    <= !rd_entry[DW];
                IRQ      <= rd_entry[DW+2];
                IRQ_VLD  <= rd_entry[DW+1];
            end else begin
                WRITE <= 1'b0;
                IRQ   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sh_hf_adaptor_fifo.sv
// Directed bench for sh_hf_adaptor_fifo: one instance strips the CRC word,
// a second one does not; both share stimulus and are checked side by side.
module tb_sh_hf_adaptor_fifo;

    localparam logic [1:0] MY   = 2'h0;
    localparam logic [1:0] IDLE = 2'h1;

    logic        clk;
    logic        rst;
    logic [1:0]  turn;
    logic [31:0] din;
    logic        wr;
    logic        np;
    logic        npv;

    logic [31:0] o1_data, o0_data;
    logic        o1_write, o0_write;
    logic        o1_irq, o0_irq;
    logic        o1_irqv, o0_irqv;
    logic        o1_ovf, o0_ovf;
    logic [3:0]  o1_lvl, o0_lvl;

    int checks = 0;
    int errors = 0;

    sh_hf_adaptor_fifo #(.DW(32), .DEPTH_LOG2(3), .MY_SLOT(2'h0), .STRIP_CRC(1)) u1 (
        .CLK(clk), .RST(rst), .LSAB_TURN(turn), .DATA_FROM_ETH(din), .WRITE_IN(wr),
        .NEW_PCKT(np), .NEW_PCKT_VALID(npv), .DATA_OUT(o1_data), .WRITE(o1_write),
        .IRQ(o1_irq), .IRQ_VLD(o1_irqv), .OVERFLOW(o1_ovf), .LEVEL(o1_lvl)
    );

    sh_hf_adaptor_fifo #(.DW(32), .DEPTH_LOG2(3), .MY_SLOT(2'h0), .STRIP_CRC(0)) u0 (
        .CLK(clk), .RST(rst), .LSAB_TURN(turn), .DATA_FROM_ETH(din), .WRITE_IN(wr),
        .NEW_PCKT(np), .NEW_PCKT_VALID(npv), .DATA_OUT(o0_data), .WRITE(o0_write),
        .IRQ(o0_irq), .IRQ_VLD(o0_irqv), .OVERFLOW(o0_ovf), .LEVEL(o0_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        wr  = 1'b1;
        din = w;
        tick();
        wr  = 1'b0;
    endtask

    task automatic fe_pulse(input logic v);
        np  = 1'b1;
        npv = v;
        tick();
        np  = 1'b0;
        npv = 1'b0;
    endtask

    task automatic do_pop();
        turn = MY;
        tick();
        turn = IDLE;
    endtask

    task automatic out_chk(input string tag, input int sel, input logic [31:0] d,
                           input logic w, input logic i, input logic v,
                           input bit cd, input bit cv);
        logic [31:0] od;
        logic        ow, oi, ov;
        if (sel == 1) begin
            od = o1_data; ow = o1_write; oi = o1_irq; ov = o1_irqv;
        end else begin
            od = o0_data; ow = o0_write; oi = o0_irq; ov = o0_irqv;
        end
        if (cd) chk({tag, "/data"}, 64'(od), 64'(d));
        chk({tag, "/write"}, 64'(ow), 64'(w));
        chk({tag, "/irq"}, 64'(oi), 64'(i));
        if (cv) chk({tag, "/irq_vld"}, 64'(ov), 64'(v));
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "/u1_data"}, 64'(o1_data), 64'(0));
        chk({tag, "/u1_write"}, 64'(o1_write), 64'(0));
        chk({tag, "/u1_irq"}, 64'(o1_irq), 64'(0));
        chk({tag, "/u1_irqv"}, 64'(o1_irqv), 64'(0));
        chk({tag, "/u1_ovf"}, 64'(o1_ovf), 64'(0));
        chk({tag, "/u1_lvl"}, 64'(o1_lvl), 64'(0));
        chk({tag, "/u0_data"}, 64'(o0_data), 64'(0));
        chk({tag, "/u0_write"}, 64'(o0_write), 64'(0));
        chk({tag, "/u0_irq"}, 64'(o0_irq), 64'(0));
        chk({tag, "/u0_irqv"}, 64'(o0_irqv), 64'(0));
        chk({tag, "/u0_ovf"}, 64'(o0_ovf), 64'(0));
        chk({tag, "/u0_lvl"}, 64'(o0_lvl), 64'(0));
    endtask

    initial begin
        rst  = 1'b0;
        turn = IDLE;
        din  = '0;
        wr   = 1'b0;
        np   = 1'b0;
        npv  = 1'b0;
        #1 rst = 1'b1;
        #1;
        rst_chk("por");
        tick();
        tick();
        rst = 1'b0;

        // Frame A..D, frame good
        push(32'h0000_00A1);
        push(32'h0000_00B2);
        push(32'h0000_00C3);
        push(32'h0000_00D4);
        fe_pulse(1'b1);
        chk("f1/u1_lvl", 64'(o1_lvl), 64'(3));
        chk("f1/u0_lvl", 64'(o0_lvl), 64'(4));

        do_pop();
        out_chk("f1p1u1", 1, 32'h0000_00A1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f1p1u0", 0, 32'h0000_00A1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        out_chk("f1hold", 1, 32'h0000_00A1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("f1hold/u1_lvl", 64'(o1_lvl), 64'(2));

        do_pop();
        out_chk("f1p2u1", 1, 32'h0000_00B2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f1p2u0", 0, 32'h0000_00B2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("f1p3u1", 1, 32'h0000_00C3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        out_chk("f1p3u0", 0, 32'h0000_00C3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("f1p4u1", 1, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f1p4u0", 0, 32'h0000_00D4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        do_pop();
        out_chk("f1p5u1", 1, 32'h0000_00C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f1p5u0", 0, 32'h0000_00D4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Same shape, frame bad
        push(32'h0000_0011);
        push(32'h0000_0012);
        push(32'h0000_0013);
        push(32'h0000_0014);
        fe_pulse(1'b0);
        do_pop();
        out_chk("f2p1u1", 1, 32'h0000_0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f2p1u0", 0, 32'h0000_0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("f2p2u1", 1, 32'h0000_0012, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f2p2u0", 0, 32'h0000_0012, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("f2p3u1", 1, 32'h0000_0013, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        out_chk("f2p3u0", 0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("f2p4u1", 1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("f2p4u0", 0, 32'h0000_0014, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Empty frame, popped on the very next edge
        fe_pulse(1'b1);
        do_pop();
        out_chk("emptyu1", 1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        out_chk("emptyu0", 0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_pop();
        out_chk("empty2u1", 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_chk("empty2u0", 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Word and frame end in the same cycle
        push(32'h0000_0021);
        push(32'h0000_0022);
        wr  = 1'b1;
        din = 32'h0000_0023;
        np  = 1'b1;
        npv = 1'b1;
        tick();
        wr  = 1'b0;
        np  = 1'b0;
        npv = 1'b0;
        chk("same/u1_lvl", 64'(o1_lvl), 64'(1));
        chk("same/u0_lvl", 64'(o0_lvl), 64'(2));
        do_pop();
        out_chk("samep1u1", 1, 32'h0000_0022, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        out_chk("samep1u0", 0, 32'h0000_0021, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("samep2u1", 1, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("samep2u0", 0, 32'h0000_0023, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        do_pop();
        chk("same/u0_lvl_end", 64'(o0_lvl), 64'(0));

        // Overflow: 12 words with no turn, then frame end
        for (int i = 0; i < 12; i++) begin
            push(32'h0000_0100 + 32'(i));
        end
        fe_pulse(1'b1);
        chk("ovf/u1_ovf", 64'(o1_ovf), 64'(1));
        chk("ovf/u0_ovf", 64'(o0_ovf), 64'(1));
        chk("ovf/u1_lvl", 64'(o1_lvl), 64'(8));
        chk("ovf/u0_lvl", 64'(o0_lvl), 64'(8));
        for (int i = 0; i < 8; i++) begin
            do_pop();
            out_chk("ovfwu1", 1, 32'h0000_0100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            out_chk("ovfwu0", 0, 32'h0000_0100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        do_pop();
        out_chk("ovftagu1", 1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        out_chk("ovftagu0", 0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        do_pop();
        out_chk("ovfendu1", 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_chk("ovfendu0", 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovfend/u1_ovf", 64'(o1_ovf), 64'(1));
        chk("ovfend/u1_lvl", 64'(o1_lvl), 64'(0));

        // Asynchronous reset in the middle of a frame
        push(32'h0000_0051);
        push(32'h0000_0052);
        push(32'h0000_0053);
        chk("mid/u1_lvl", 64'(o1_lvl), 64'(1));
        chk("mid/u0_lvl", 64'(o0_lvl), 64'(2));
        #3 rst = 1'b1;
        #1;
        rst_chk("async");
        #2 rst = 1'b0;
        do_pop();
        out_chk("postrst1u1", 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("postrst1u0", 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_pop();
        out_chk("postrst2u1", 1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        out_chk("postrst2u0", 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("postrst/u1_lvl", 64'(o1_lvl), 64'(0));
        chk("postrst/u0_lvl", 64'(o0_lvl), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
